nes_rom_loader_ctrl: RTL

Sequences game-ROM loading from the SoC ROM-programmer conduit into the NES PRG and CHR ROM write ports, and holds the NES CPU in reset until the image is complete. It sits between the SoC conduit (address, data, PRG/CHR write levels) and the NES architecture's ROM write ports and CPU reset. It edge-detects each programmer write, buffers it in a small FIFO, and issues it only when the memory port is free. It counts bytes per ROM, flags protocol errors, and releases the CPU after a settle delay.

---
 rtl/nes_loader_pkg.sv | 23 ++
 rtl/loader_fifo.sv | 73 +++++++
 rtl/nes_rom_loader_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nes_loader_pkg.sv
// Shared types for the NES ROM loader: FSM states, error bit
// positions and the buffered write entry.
package nes_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD,
        ST_RUN
    } loader_state_e;

    localparam int ERR_OVF      = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_CONFLICT = 2;

    typedef struct packed {
        logic        is_chr;
        logic [15:0] addr;
        logic [7:0]  data;
    } loader_entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Small circular buffer for pending ROM writes.
// A push into a full FIFO succeeds only alongside a pop in the same cycle.
module loader_fifo
    import nes_loader_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = loader_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   flush,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nes_rom_loader_ctrl.sv
// Moves programmer conduit writes into the NES PRG/CHR ROM ports
// and holds the CPU in reset until the whole image has landed.
module nes_rom_loader_ctrl
    import nes_loader_pkg::*;
#(
    parameter int PRG_BYTES      = 32768,
    parameter int CHR_BYTES      = 8192,
    parameter int FIFO_DEPTH     = 4,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [15:0] prgmr_addr,
    input  logic [7:0]  prgmr_data,
    input  logic        prg_wren,
    input  logic        chr_wren,
    input  logic        port_free,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        prg_we,
    output logic        chr_we,
    output logic        cpu_reset_hold,
    output logic        loaded,
    output logic [2:0]  err
);

    localparam int PW = $clog2(PRG_BYTES + 1);
    localparam int CW = $clog2(CHR_BYTES + 1);
    localparam int HW = $clog2(RELEASE_CYCLES + 1);

    localparam logic [PW-1:0] PRG_MAX  = PW'(PRG_BYTES);
    localparam logic [CW-1:0] CHR_MAX  = CW'(CHR_BYTES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RELEASE_CYCLES);

    loader_state_e state_q, state_d;
    logic          prev_prg_q, prev_prg_d;
    logic          prev_chr_q, prev_chr_d;
    logic [PW-1:0] prg_cnt_q, prg_cnt_d;
    logic [CW-1:0] chr_cnt_q, chr_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]    err_q, err_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_data_q, mem_data_d;
    logic          prg_we_q, prg_we_d;
    logic          chr_we_q, chr_we_d;
    logic          cpu_reset_hold_q, cpu_reset_hold_d;
    logic          loaded_q, loaded_d;

    logic          prg_edge;
    logic          chr_edge;
    logic          any_edge;
    logic          prg_ok;
    logic          chr_ok;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    loader_entry_t push_entry;
    loader_entry_t fifo_head;

    assign prev_prg_d = prg_wren;
    assign prev_chr_d = chr_wren;
    assign prg_edge   = prg_wren & ~prev_prg_q;
    assign chr_edge   = chr_wren & ~prev_chr_q;
    assign any_edge   = prg_edge | chr_edge;

    assign prg_ok = ({16'b0, prgmr_addr} < 32'(PRG_BYTES))
                  && (prg_cnt_q < PRG_MAX);
    assign chr_ok = ({16'b0, prgmr_addr} < 32'(CHR_BYTES))
                  && (chr_cnt_q < CHR_MAX);

    // A restart wins over draining: nothing leaves the FIFO that cycle.
    assign fifo_pop = ~fifo_empty & port_free & ~load_start;

    always_comb begin
        push_entry.is_chr = chr_edge;
        push_entry.addr   = prgmr_addr;
        push_entry.data   = prgmr_data;
    end

    always_comb begin
        state_d          = state_q;
        prg_cnt_d        = prg_cnt_q;
        chr_cnt_d        = chr_cnt_q;
        hold_cnt_d       = hold_cnt_q;
        err_d            = err_q;
        mem_addr_d       = mem_addr_q;
        mem_data_d       = mem_data_q;
        prg_we_d         = 1'b0;
        chr_we_d         = 1'b0;
        cpu_reset_hold_d = cpu_reset_hold_q;
        loaded_d         = loaded_q;
        fifo_push        = 1'b0;
        fifo_flush       = 1'b0;

        if (fifo_pop) begin
            mem_addr_d = fifo_head.addr;
            mem_data_d = fifo_head.data;
            prg_we_d   = ~fifo_head.is_chr;
            chr_we_d   = fifo_head.is_chr;
        end

        if (load_start) begin
            state_d          = ST_LOAD;
            fifo_flush       = 1'b1;
            prg_cnt_d        = '0;
            chr_cnt_d        = '0;
            hold_cnt_d       = '0;
            err_d            = '0;
            cpu_reset_hold_d = 1'b1;
            loaded_d         = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_LOAD: begin
                    if (prg_edge && chr_edge) begin
                        err_d[ERR_CONFLICT] = 1'b1;
                    end else if (any_edge) begin
                        if (!(chr_edge ? chr_ok : prg_ok)) begin
                            err_d[ERR_RANGE] = 1'b1;
                        end else if (fifo_full && !fifo_pop) begin
                            err_d[ERR_OVF] = 1'b1;
                        end else begin
                            fifo_push = 1'b1;
                            if (chr_edge) begin
                                chr_cnt_d = chr_cnt_q + CW'(1);
                            end else begin
                                prg_cnt_d = prg_cnt_q + PW'(1);
                            end
                        end
                    end
                    if (prg_cnt_q == PRG_MAX && chr_cnt_q == CHR_MAX) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (any_edge) begin
                        err_d[ERR_RANGE] = 1'b1;
                    end
                    // The last pop's strobe is registered as this exit happens.
                    if (fifo_empty) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (any_edge) begin
                        err_d[ERR_RANGE] = 1'b1;
                    end
                    if (hold_cnt_q == HOLD_MAX) begin
                        state_d          = ST_RUN;
                        cpu_reset_hold_d = 1'b0;
                        loaded_d         = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                ST_RUN: begin
                    if (any_edge) begin
                        err_d[ERR_RANGE] = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            prev_prg_q       <= 1'b0;
            prev_chr_q       <= 1'b0;
            prg_cnt_q        <= '0;
            chr_cnt_q        <= '0;
            hold_cnt_q       <= '0;
            err_q            <= '0;
            mem_addr_q       <= '0;
            mem_data_q       <= '0;
            prg_we_q         <= 1'b0;
            chr_we_q         <= 1'b0;
            cpu_reset_hold_q <= 1'b1;
            loaded_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            prev_prg_q       <= prev_prg_d;
            prev_chr_q       <= prev_chr_d;
            prg_cnt_q        <= prg_cnt_d;
            chr_cnt_q        <= chr_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            err_q            <= err_d;
            mem_addr_q       <= mem_addr_d;
            mem_data_q       <= mem_data_d;
            prg_we_q         <= prg_we_d;
            chr_we_q         <= chr_we_d;
            cpu_reset_hold_q <= cpu_reset_hold_d;
            loaded_q         <= loaded_d;
        end
    end

    loader_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (loader_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign prg_we         = prg_we_q;
    assign chr_we         = chr_we_q;
    assign cpu_reset_hold = cpu_reset_hold_q;
    assign loaded         = loaded_q;
    assign err            = err_q;

endmodule
